motion_sched: RTL and testbench
===============================

MOTION_SCHED -- requirements
Module: motion_sched

Interface
REQ-001 Parameter DEAD_CYC, default 16'd5000, number of clock cycles all motor lines are held low on a direction or owner change.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 trk_req  input  1  line-tracking requester wants the motors.
REQ-005 trk_cmd  input  4  tracking command {IN4,IN3,IN2,IN1}.
REQ-006 avd_req  input  1  obstacle-avoidance requester wants the motors.
REQ-007 avd_cmd  input  4  avoidance command, same encoding.
REQ-008 rmt_req  input  1  remote-control requester wants the motors.
REQ-009 rmt_cmd  input  4  remote command, same encoding.
REQ-010 duty  input  8  speed; PWM high time in counts of 256.
REQ-011 motor  output  4  driver lines {IN4,IN3,IN2,IN1}.
REQ-012 grant  output  3  one-hot current owner {avd,rmt,trk}; 000 = none.
REQ-013 dead  output  1  high while in DEAD state.

Function
REQ-014 Encoding: side A = {IN4,IN3}, side B = {IN2,IN1}; per side, IN4/IN1 = forward, IN3/IN2 = reverse, 00 = stop, 11 = illegal and SHALL be treated as stop (00).
REQ-015 Each side has a direction: FWD, REV or STOP, derived after the illegal-to-stop mapping.
REQ-016 Arbitration SHALL be fixed priority, avd > rmt > trk, evaluated every cycle; the winner is the highest-priority asserted req.
REQ-017 PWM: 8-bit free-running counter pcnt, increments every cycle, wraps 255->0; pwm_on = (pcnt < duty); duty=0 gives never on, duty=255 gives 255/256 on.
REQ-018 States: IDLE, RUN, DEAD.
REQ-019 IDLE: grant=000, motor=0000; when any req is asserted, set grant to the winner and go to RUN if no side reverses, else go to DEAD.
REQ-020 RUN: motor = sanitized winner cmd AND {4{pwm_on}}, registered, with 1-cycle latency from cmd/req to motor.
REQ-021 RUN to DEAD when, in the same cycle, the winner differs from grant, or either side changes FWD<->REV against the last applied direction; STOP<->FWD/REV changes SHALL NOT enter DEAD.
REQ-022 RUN to IDLE when no req is asserted; motor=0000 next cycle, and the last applied direction is kept.
REQ-023 DEAD: motor=0000 and dead=1; dead counter loads DEAD_CYC-1 on entry and decrements each cycle; grant updates to the new winner on entry.
REQ-024 On DEAD exit (counter==0), go to RUN with the then-current winner; if no req is asserted, go to IDLE.
REQ-025 Winner change during DEAD: grant follows the winner; the counter SHALL NOT restart.
REQ-026 Last applied direction per side SHALL update only on RUN cycles.
REQ-027 Simultaneous owner change and direction reversal SHALL produce a single DEAD window.
REQ-028 DEAD_CYC=0 or 1 SHALL give exactly one DEAD cycle.
REQ-029 The duty value is sampled every cycle; a change takes effect on the next pcnt comparison, without resetting pcnt.

Reset
REQ-030 While rst_n=0: motor=0000, grant=000, dead=0, state=IDLE, pcnt=0, dead counter=0, last directions=STOP.
REQ-031 Reset assertion mid-DEAD or mid-RUN SHALL force all of REQ-030 immediately, without waiting for clk.
REQ-032 After reset release, the first direction applied SHALL NOT incur DEAD, because the last direction is STOP.

Verification
REQ-033 Apply duty=128, trk_req=1, trk_cmd=1001 -> grant=001 and no DEAD; motor toggles 1001/0000 with 128 cycles high per 256.
REQ-034 While trk runs FWD/FWD, assert avd_req with avd_cmd=0110 -> DEAD_CYC cycles of motor=0000 with dead=1 and grant=100, then motor=0110 gated by pwm_on.
REQ-035 Set trk_cmd=1100 (illegal side A) with duty=255 -> side A lines stay 00; side B is stop, so motor=0000 and no DEAD.
REQ-036 trk_cmd changes 1001 to 0001 to 0011 -> no DEAD on the STOP change; DEAD only when side B reverses, which is 01 to 10 mapped from 0001 to 0010.
REQ-037 Assert rst_n=0 mid-DEAD -> outputs are 0 immediately; after release with rmt_req=1 and rmt_cmd=0110, RUN follows with no DEAD.
REQ-038 With duty=0 or all req=0 -> motor=0000 for 512 cycles.

Source files
------------

// File: rtl/motion_sched.sv
// Motor-line scheduler: fixed-priority arbitration of three requesters onto one
// H-bridge pair, PWM speed gating, and a dead window on owner change or reversal.
module motion_sched #(
    parameter logic [15:0] DEAD_CYC = 16'd5000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trk_req,
    input  logic [3:0] trk_cmd,
    input  logic       avd_req,
    input  logic [3:0] avd_cmd,
    input  logic       rmt_req,
    input  logic [3:0] rmt_cmd,
    input  logic [7:0] duty,
    output logic [3:0] motor,
    output logic [2:0] grant,
    output logic       dead
);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DEAD = 2'd2} state_t;
    typedef enum logic [1:0] {DIR_STOP = 2'd0, DIR_FWD = 2'd1, DIR_REV = 2'd2} dir_t;

    localparam logic [15:0] DEAD_LOAD = (DEAD_CYC == 16'd0) ? 16'd0 : DEAD_CYC - 16'd1;

    function automatic logic [1:0] sanitize(input logic [1:0] side);
        return (side == 2'b11) ? 2'b00 : side;
    endfunction

    // fwd_msb selects which line of the pair means forward (IN4 on side A, IN1 on side B)
    function automatic dir_t side_dir(input logic [1:0] side, input logic fwd_msb);
        if (side == 2'b00 || side == 2'b11) begin
            return DIR_STOP;
        end else if (side[1] == fwd_msb) begin
            return DIR_FWD;
        end else begin
            return DIR_REV;
        end
    endfunction

    function automatic logic reverses(input dir_t last_dir, input dir_t cur_dir);
        return (last_dir == DIR_FWD && cur_dir == DIR_REV) ||
               (last_dir == DIR_REV && cur_dir == DIR_FWD);
    endfunction

    state_t      state_q, state_d;
    dir_t        last_a_q, last_a_d, last_b_q, last_b_d;
    dir_t        dir_a_s, dir_b_s;
    logic [3:0]  motor_q, motor_d;
    logic [2:0]  grant_q, grant_d;
    logic        dead_q, dead_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  pcnt_q, pcnt_d;
    logic [2:0]  win_s;
    logic [3:0]  win_cmd_s, clean_cmd_s;
    logic        any_req_s, rev_s, pwm_on_s, apply_s;

    // Fixed-priority winner selection: avd > rmt > trk
    always_comb begin
        win_s     = 3'b000;
        win_cmd_s = 4'b0000;
        if (avd_req) begin
            win_s     = 3'b100;
            win_cmd_s = avd_cmd;
        end else if (rmt_req) begin
            win_s     = 3'b010;
            win_cmd_s = rmt_cmd;
        end else if (trk_req) begin
            win_s     = 3'b001;
            win_cmd_s = trk_cmd;
        end else begin
            win_s     = 3'b000;
            win_cmd_s = 4'b0000;
        end
    end

    assign any_req_s   = avd_req | rmt_req | trk_req;
    assign clean_cmd_s = {sanitize(win_cmd_s[3:2]), sanitize(win_cmd_s[1:0])};
    assign dir_a_s     = side_dir(clean_cmd_s[3:2], 1'b1);
    assign dir_b_s     = side_dir(clean_cmd_s[1:0], 1'b0);
    assign rev_s       = reverses(last_a_q, dir_a_s) | reverses(last_b_q, dir_b_s);
    assign pwm_on_s    = (pcnt_q < duty);
    assign pcnt_d      = pcnt_q + 8'd1;

    // Next-state, grant and dead-counter logic; apply_s marks a cycle that drives the winner
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        cnt_d    = cnt_q;
        apply_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_req_s) begin
                    grant_d = win_s;
                    if (rev_s) begin
                        state_d = ST_DEAD;
                        cnt_d   = DEAD_LOAD;
                    end else begin
                        state_d = ST_RUN;
                        apply_s = 1'b1;
                    end
                end else begin
                    grant_d = 3'b000;
                end
            end
            ST_RUN: begin
                if (!any_req_s) begin
                    state_d = ST_IDLE;
                    grant_d = 3'b000;
                end else if (win_s != grant_q || rev_s) begin
                    state_d = ST_DEAD;
                    grant_d = win_s;
                    cnt_d   = DEAD_LOAD;
                end else begin
                    apply_s = 1'b1;
                end
            end
            ST_DEAD: begin
                grant_d = win_s;
                if (cnt_q == 16'd0) begin
                    if (any_req_s) begin
                        state_d = ST_RUN;
                        apply_s = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 3'b000;
                cnt_d   = 16'd0;
            end
        endcase
    end

    // Motor lines and remembered directions only move on cycles that drive the winner
    always_comb begin
        motor_d  = 4'b0000;
        last_a_d = last_a_q;
        last_b_d = last_b_q;
        if (apply_s) begin
            motor_d  = clean_cmd_s & {4{pwm_on_s}};
            last_a_d = dir_a_s;
            last_b_d = dir_b_s;
        end else begin
            motor_d  = 4'b0000;
        end
        dead_d = (state_d == ST_DEAD);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            motor_q  <= 4'b0000;
            grant_q  <= 3'b000;
            dead_q   <= 1'b0;
            cnt_q    <= 16'd0;
            pcnt_q   <= 8'd0;
            last_a_q <= DIR_STOP;
            last_b_q <= DIR_STOP;
        end else begin
            state_q  <= state_d;
            motor_q  <= motor_d;
            grant_q  <= grant_d;
            dead_q   <= dead_d;
            cnt_q    <= cnt_d;
            pcnt_q   <= pcnt_d;
            last_a_q <= last_a_d;
            last_b_q <= last_b_d;
        end
    end

    assign motor = motor_q;
    assign grant = grant_q;
    assign dead  = dead_q;

endmodule

// File: tb/tb_motion_sched.sv
// Scoreboard bench for motion_sched: directed per-cycle expectations queued by the
// stimulus, popped and compared by an independent monitor after each rising edge.
module tb_motion_sched;

    localparam logic [15:0] DC = 16'd16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       trk_req, avd_req, rmt_req;
    logic [3:0] trk_cmd, avd_cmd, rmt_cmd;
    logic [7:0] duty;
    logic [3:0] motor, motor2;
    logic [2:0] grant, grant2;
    logic       dead, dead2;

    typedef struct {
        logic [3:0] motor;
        logic [2:0] grant;
        logic       dead;
        string      tag;
    } exp_t;

    exp_t       sb_q[$];
    int         n_vec  = 0;
    int         n_fail = 0;
    logic [7:0] pc     = 8'd0;
    string      phase  = "reset";
    int         d2_cycles = 0, d2_windows = 0;
    logic       d2_prev = 1'b0;

    motion_sched #(.DEAD_CYC(DC)) dut (
        .clk(clk), .rst_n(rst_n),
        .trk_req(trk_req), .trk_cmd(trk_cmd),
        .avd_req(avd_req), .avd_cmd(avd_cmd),
        .rmt_req(rmt_req), .rmt_cmd(rmt_cmd),
        .duty(duty), .motor(motor), .grant(grant), .dead(dead)
    );

    motion_sched #(.DEAD_CYC(16'd0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .trk_req(trk_req), .trk_cmd(trk_cmd),
        .avd_req(avd_req), .avd_cmd(avd_cmd),
        .rmt_req(rmt_req), .rmt_cmd(rmt_cmd),
        .duty(duty), .motor(motor2), .grant(grant2), .dead(dead2)
    );

    always #5 clk = ~clk;

    // Monitor: one expected entry per rising edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                n_vec++;
                if (motor !== e.motor || grant !== e.grant || dead !== e.dead) begin
                    n_fail++;
                    $display("FAIL %s t=%0t motor/grant/dead got %b/%b/%b exp %b/%b/%b",
                             e.tag, $time, motor, grant, dead, e.motor, e.grant, e.dead);
                end
            end
            if (dead2 && !d2_prev) d2_windows++;
            if (dead2) d2_cycles++;
            d2_prev = dead2;
        end
    end

    task automatic check_now(input string tag, input logic [3:0] em, input logic [2:0] eg,
                             input logic ed);
        n_vec++;
        if (motor !== em || grant !== eg || dead !== ed) begin
            n_fail++;
            $display("FAIL %s motor/grant/dead got %b/%b/%b exp %b/%b/%b",
                     tag, motor, grant, dead, em, eg, ed);
        end
    endtask

    // Queue n cycles of expectations for the current inputs; call at a falling edge
    task automatic tick(input int n, input logic [3:0] e_cmd, input logic [2:0] e_grant,
                        input logic e_dead);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.motor = (pc < duty) ? e_cmd : 4'b0000;
            e.grant = e_grant;
            e.dead  = e_dead;
            e.tag   = phase;
            sb_q.push_back(e);
            @(negedge clk);
            pc = pc + 8'd1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        trk_req = 1'b0; avd_req = 1'b0; rmt_req = 1'b0;
        trk_cmd = 4'b0000; avd_cmd = 4'b0000; rmt_cmd = 4'b0000;
        duty = 8'd0;
        #12;
        check_now("reset", 4'b0000, 3'b000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        pc = 8'd0;

        phase = "trk_fwd_pwm128";
        duty = 8'd128; trk_req = 1'b1; trk_cmd = 4'b1001;
        tick(256, 4'b1001, 3'b001, 1'b0);

        phase = "avd_takeover_dead";
        avd_req = 1'b1; avd_cmd = 4'b0110;
        tick(16, 4'b0000, 3'b100, 1'b1);
        phase = "avd_run";
        tick(20, 4'b0110, 3'b100, 1'b0);

        phase = "all_release_idle";
        avd_req = 1'b0; trk_req = 1'b0;
        tick(3, 4'b0000, 3'b000, 1'b0);

        phase = "illegal_side_a";
        duty = 8'd255; trk_req = 1'b1; trk_cmd = 4'b1100;
        tick(5, 4'b0000, 3'b001, 1'b0);
        phase = "stop_to_fwd";
        trk_cmd = 4'b1001;
        tick(4, 4'b1001, 3'b001, 1'b0);
        phase = "fwd_to_stop_a";
        trk_cmd = 4'b0001;
        tick(4, 4'b0001, 3'b001, 1'b0);
        phase = "illegal_side_b";
        trk_cmd = 4'b0011;
        tick(3, 4'b0000, 3'b001, 1'b0);
        phase = "b_fwd_again";
        trk_cmd = 4'b0001;
        tick(3, 4'b0001, 3'b001, 1'b0);
        phase = "b_reverse_dead";
        trk_cmd = 4'b0010;
        tick(16, 4'b0000, 3'b001, 1'b1);
        phase = "b_rev_run";
        tick(5, 4'b0010, 3'b001, 1'b0);

        phase = "idle_keeps_dir";
        trk_req = 1'b0;
        tick(3, 4'b0000, 3'b000, 1'b0);
        phase = "idle_reverse_dead";
        trk_req = 1'b1; trk_cmd = 4'b0001;
        tick(16, 4'b0000, 3'b001, 1'b1);
        phase = "idle_reverse_run";
        tick(5, 4'b0001, 3'b001, 1'b0);

        phase = "rmt_takeover_dead";
        rmt_req = 1'b1; rmt_cmd = 4'b0110;
        tick(5, 4'b0000, 3'b010, 1'b1);
        phase = "avd_during_dead";
        avd_req = 1'b1; avd_cmd = 4'b1010;
        tick(11, 4'b0000, 3'b100, 1'b1);
        phase = "avd_after_dead";
        tick(5, 4'b1010, 3'b100, 1'b0);

        phase = "avd_reverse_dead";
        avd_cmd = 4'b0110;
        tick(3, 4'b0000, 3'b100, 1'b1);
        phase = "dead_no_req";
        avd_req = 1'b0; rmt_req = 1'b0; trk_req = 1'b0;
        tick(13, 4'b0000, 3'b000, 1'b1);
        phase = "dead_exit_idle";
        tick(3, 4'b0000, 3'b000, 1'b0);

        phase = "trk_reverse_dead";
        trk_req = 1'b1; trk_cmd = 4'b0101;
        tick(5, 4'b0000, 3'b001, 1'b1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_now("async_rst_mid_dead", 4'b0000, 3'b000, 1'b0);
        repeat (3) @(negedge clk);
        check_now("rst_hold", 4'b0000, 3'b000, 1'b0);
        rst_n = 1'b1;
        pc = 8'd0;
        phase = "rmt_after_reset";
        trk_req = 1'b0; rmt_req = 1'b1; rmt_cmd = 4'b0110;
        tick(10, 4'b0110, 3'b010, 1'b0);

        phase = "duty_zero";
        duty = 8'd0;
        tick(512, 4'b0110, 3'b010, 1'b0);
        phase = "no_req";
        duty = 8'd128; rmt_req = 1'b0;
        tick(512, 4'b0000, 3'b000, 1'b0);

        @(posedge clk);
        #2;
        n_vec++;
        if (d2_windows == 0 || d2_cycles != d2_windows) begin
            n_fail++;
            $display("FAIL dead_cyc0_one_cycle dead cycles %0d windows %0d exp equal and nonzero",
                     d2_cycles, d2_windows);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
